// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and sizing for the FIFO read-side stream master.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        FLUSH
    } rd_state_e;

    localparam int unsigned BUF_ENTRIES = 2;
    localparam int unsigned OCC_W       = $clog2(BUF_ENTRIES + 1);

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Valid/ready output stream with burst framing.
interface fifo_stream_reader_if #(
    parameter int WIDTH = 32
);

    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;

    modport master (output m_valid, m_data, m_last, input m_ready);
    modport slave  (input m_valid, m_data, m_last, output m_ready);

endinterface

// File: rtl/fifo_stream_reader_out_buf.sv
// Two-entry valid/ready skid buffer; head register drives the output word.
module fifo_out_buf
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [OCC_W-1:0] occ
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            // Credit logic upstream guarantees no push lands in a full, non-draining buffer.
            assert (!(push && !pop && occ == OCC_W'(BUF_ENTRIES)));
            assert (!(pop && occ == '0));
            unique case ({push, pop})
                2'b10: begin
                    if (occ == '0) head <= push_data;
                    else           tail <= push_data;
                    occ <= occ + 1'b1;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 1'b1;
                end
                2'b11: begin
                    if (occ == OCC_W'(1)) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = (occ != '0);
    assign data  = head;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for the sync FIFO: issues reads against output-buffer credit
// and presents the words as a framed valid/ready stream.
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int BURST = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 fifo_empty,
    input  logic                 fifo_write,
    input  logic [WIDTH-1:0]     fifo_data,
    output logic                 fifo_read,
    fifo_stream_reader_if.master m,
    output logic [CNT_W-1:0]     words_out
);

    localparam int BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;

    rd_state_e         state;
    logic              pending;
    logic              pop;
    logic              rd_acc;
    logic              capture;
    logic              buf_valid;
    logic [WIDTH-1:0]  buf_data;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W:0]    credit;
    logic [BEAT_W-1:0] beat_cnt;

    assign pop    = m.m_valid && m.m_ready;
    // Buffer slots already spoken for once this cycle's pop leaves.
    assign credit = {1'b0, occ} + {{OCC_W{1'b0}}, pending} - {{OCC_W{1'b0}}, pop};

    assign fifo_read = !reset && !clear && (state != FLUSH) && !fifo_empty && !fifo_write
                       && (credit < (OCC_W+1)'(BUF_ENTRIES));
    assign rd_acc    = fifo_read && !fifo_write && !fifo_empty;
    assign capture   = pending && !clear;

    fifo_out_buf #(.WIDTH(WIDTH)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (clear),
        .push      (capture),
        .push_data (fifo_data),
        .pop       (pop),
        .valid     (buf_valid),
        .data      (buf_data),
        .occ       (occ)
    );

    assign m.m_valid = buf_valid;
    assign m.m_data  = buf_data;
    assign m.m_last  = buf_valid && (beat_cnt == BEAT_W'(BURST - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (DEPTH >= int'(BUF_ENTRIES) && BURST >= 1);
            state     <= IDLE;
            pending   <= 1'b0;
            beat_cnt  <= '0;
            words_out <= '0;
        end else if (clear) begin
            state    <= FLUSH;
            pending  <= 1'b0;
            beat_cnt <= '0;
        end else begin
            pending <= rd_acc;
            if (pop) begin
                words_out <= words_out + 1'b1;
                beat_cnt  <= (beat_cnt == BEAT_W'(BURST - 1)) ? '0 : beat_cnt + 1'b1;
            end
            unique case (state)
                IDLE:    if (rd_acc) state <= ACTIVE;
                ACTIVE:  if (occ == '0 && !pending && !rd_acc) state <= IDLE;
                FLUSH:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench: a FIFO model feeds two readers (BURST=4 and BURST=3) in lockstep.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        fifo_empty = 1'b1;
    logic        fifo_write = 1'b0;
    logic [31:0] fifo_data = '0;
    logic [31:0] fifo_wdata = '0;
    logic        fifo_read;
    logic        fifo_read3;
    logic        m_ready = 1'b0;
    logic [15:0] words_out;
    logic [15:0] words3;

    int unsigned fq[$];
    int unsigned sb_q[$];
    int n_tests = 0;
    int n_fail = 0;
    int rd_cnt = 0;
    int inflight = 0;
    int beat4 = 0;
    int beat3 = 0;
    int exp_words = 0;
    int last3_pops = 0;
    int unsigned next_val = 100;
    logic        hold = 1'b0;
    logic [31:0] hold_data = '0;
    int unsigned e;

    fifo_stream_reader_if #(.WIDTH(32)) s4 ();
    fifo_stream_reader_if #(.WIDTH(32)) s3 ();
    assign s4.m_ready = m_ready;
    assign s3.m_ready = m_ready;

    fifo_stream_reader #(.WIDTH(32), .DEPTH(8), .BURST(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .clear(clear), .fifo_empty(fifo_empty),
        .fifo_write(fifo_write), .fifo_data(fifo_data), .fifo_read(fifo_read),
        .m(s4), .words_out(words_out)
    );

    fifo_stream_reader #(.WIDTH(32), .DEPTH(8), .BURST(3), .CNT_W(16)) dut3 (
        .clk(clk), .reset(reset), .clear(clear), .fifo_empty(fifo_empty),
        .fifo_write(fifo_write), .fifo_data(fifo_data), .fifo_read(fifo_read3),
        .m(s3), .words_out(words3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // FIFO model with registered read data; ignores reads while writing or empty.
    always @(posedge clk) begin
        if (fifo_read && !fifo_write && fq.size() > 0) begin
            fifo_data <= fq.pop_front();
            rd_cnt++;
            inflight++;
        end
        if (fifo_write) fq.push_back(fifo_wdata);
        if (s4.m_valid && m_ready && !reset && !clear) inflight--;
        if (reset) begin
            inflight = 0;
        end else if (clear) begin
            for (int i = 0; i < inflight; i++) if (sb_q.size() > 0) void'(sb_q.pop_front());
            inflight = 0;
        end
        fifo_empty <= (fq.size() == 0);
    end

    always @(negedge clk) begin
        if (reset) begin
            beat4 = 0; beat3 = 0; exp_words = 0; hold = 1'b0;
        end else begin
            if (hold) begin
                check("hold_valid", s4.m_valid, 1);
                check("hold_data", s4.m_data, hold_data);
            end
            if (s4.m_valid) check("last4", s4.m_last, beat4 == 3);
            else            check("last4_idle", s4.m_last, 0);
            if (s3.m_valid) check("last3", s3.m_last, beat3 == 2);
            else            check("last3_idle", s3.m_last, 0);
            check("words4", words_out, exp_words[15:0]);
            check("words3", words3, exp_words[15:0]);
            check("rd_legal", fifo_read && (fifo_empty || fifo_write), 0);
            check("rd3_legal", fifo_read3 && (fifo_empty || fifo_write), 0);
            hold      = s4.m_valid && !m_ready && !clear;
            hold_data = s4.m_data;
            if (clear) begin
                beat4 = 0; beat3 = 0;
            end else if (s4.m_valid && m_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("data4", s4.m_data, e);
                    check("data3", s3.m_data, e);
                    check("valid3", s3.m_valid, 1);
                end
                if (s3.m_last) last3_pops++;
                beat4 = (beat4 == 3) ? 0 : beat4 + 1;
                beat3 = (beat3 == 2) ? 0 : beat3 + 1;
                exp_words++;
            end
        end
    end

    task automatic do_reset(input int n, input int unsigned base);
        reset = 1'b1; clear = 1'b0; fifo_write = 1'b0; m_ready = 1'b0;
        fq.delete(); sb_q.delete();
        for (int i = 0; i < n; i++) begin
            fq.push_back(base + i);
            sb_q.push_back(base + i);
        end
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("rst_valid", s4.m_valid, 0);
        check("rst_data", s4.m_data, 0);
        check("rst_last", s4.m_last, 0);
        check("rst_words", words_out, 0);
        check("rst_read", fifo_read, 0);
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic write_words(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            fifo_write = 1'b1; fifo_wdata = next_val;
            sb_q.push_back(next_val); next_val++;
        end
        @(posedge clk); #1 fifo_write = 1'b0;
    endtask

    task automatic run_drain(input string tag, input int max, input bit rnd, input int nwr);
        int wr_left = nwr;
        for (int i = 0; i < max; i++) begin
            @(posedge clk); #1;
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (wr_left > 0 && (i % 2) == 0) begin
                fifo_write = 1'b1; fifo_wdata = next_val;
                sb_q.push_back(next_val); next_val++; wr_left--;
            end else begin
                fifo_write = 1'b0;
            end
            if (sb_q.size() == 0 && wr_left == 0) break;
        end
        fifo_write = 1'b0;
        m_ready = 1'b0;
        check(tag, sb_q.size(), 0);
    endtask

    initial begin
        int r0;
        int w_before;
        bit seen;

        // 1: preloaded 1..6, full-rate drain
        do_reset(6, 1);
        m_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 0) check("t1_first_read", fifo_read, 1);
            check("t1_valid", s4.m_valid, (i >= 2 && i < 8));
        end
        check("t1_words", words_out, 6);
        check("t1_sb", sb_q.size(), 0);
        @(posedge clk); #1 m_ready = 1'b0;

        // 2: backpressure with 5 queued words
        do_reset(5, 1);
        r0 = rd_cnt;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("t2_reads", rd_cnt - r0, 2);
        check("t2_valid", s4.m_valid, 1);
        check("t2_data", s4.m_data, 1);
        check("t2_noread", fifo_read, 0);
        run_drain("t2_drain", 40, 0, 0);

        // 3: writes on alternate cycles while draining
        run_drain("t3_drain", 80, 0, 9);

        // 4: random ready, 7 words; BURST=3 instance frames beats 3 and 6
        do_reset(7, 1);
        last3_pops = 0;
        run_drain("t4_drain", 200, 1, 0);
        check("t4_last3", last3_pops, 2);

        // 5: clear one cycle after a read is accepted
        w_before = exp_words;
        write_words(3);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = fifo_read;
        end
        check("t5_rd_seen", seen, 1);
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
        check("t5_flush_read", fifo_read, 0);
        check("t5_flush_valid", s4.m_valid, 0);
        check("t5_words", words_out, w_before);
        @(negedge clk);
        check("t5_valid2", s4.m_valid, 0);
        check("t5_sb", sb_q.size(), 2);
        run_drain("t5_drain", 40, 0, 0);

        // 6: reset with a word buffered and another in flight
        do_reset(5, 1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = s4.m_valid;
        end
        check("t6_valid_seen", seen, 1);
        reset = 1'b1;
        fq.delete(); sb_q.delete();
        @(negedge clk);
        check("t6_valid", s4.m_valid, 0);
        check("t6_data", s4.m_data, 0);
        check("t6_last", s4.m_last, 0);
        check("t6_words", words_out, 0);
        check("t6_read", fifo_read, 0);
        fq.push_back(77); fq.push_back(78);
        sb_q.push_back(77); sb_q.push_back(78);
        @(posedge clk); #1 reset = 1'b0;
        run_drain("t6_drain", 40, 0, 0);
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
